// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling.
// The rx input is synchronized and then sampled near the middle of each bit.
// A good frame updates data and pulses valid for one cycle.
// A low stop bit pulses frame_err instead, and the receiver then waits for the
// line to return high before it will accept another start bit.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   tick_cnt, tick_cnt_nxt;
  logic [2:0]      bit_idx, bit_idx_nxt;
  logic [7:0]      shreg, shreg_nxt;
  logic [7:0]      data_nxt;
  logic            valid_nxt, frame_err_nxt;

  // Two-flop synchronizer; resets to the idle-high line level so no false start appears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shreg     <= shreg_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  // Next-state logic; nothing moves and no strobe is raised on cycles without a tick.
  always_comb begin
    state_nxt     = state;
    tick_cnt_nxt  = tick_cnt;
    bit_idx_nxt   = bit_idx;
    shreg_nxt     = shreg;
    data_nxt      = data;
    valid_nxt     = 1'b0;
    frame_err_nxt = 1'b0;

    if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt    = START;
            tick_cnt_nxt = '0;
            bit_idx_nxt  = '0;
          end
        end

        START: begin
          if (tick_cnt == HALF_LAST) begin
            tick_cnt_nxt = '0;
            bit_idx_nxt  = '0;
            if (!rx_s) begin
              state_nxt = DATA;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + CW'(1);
          end
        end

        DATA: begin
          if (tick_cnt == BIT_LAST) begin
            shreg_nxt    = {rx_s, shreg[7:1]};
            tick_cnt_nxt = '0;
            bit_idx_nxt  = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state_nxt   = STOP;
              bit_idx_nxt = '0;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + CW'(1);
          end
        end

        STOP: begin
          if (tick_cnt == BIT_LAST) begin
            tick_cnt_nxt = '0;
            bit_idx_nxt  = '0;
            if (rx_s) begin
              data_nxt  = shreg;
              valid_nxt = 1'b1;
              state_nxt = IDLE;
            end else begin
              frame_err_nxt = 1'b1;
              state_nxt     = WAIT_HIGH;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + CW'(1);
          end
        end

        WAIT_HIGH: begin
          if (rx_s) begin
            state_nxt    = IDLE;
            tick_cnt_nxt = '0;
            bit_idx_nxt  = '0;
          end
        end

        default: begin
          state_nxt    = IDLE;
          tick_cnt_nxt = '0;
          bit_idx_nxt  = '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx.
// Each frame that is driven pushes its expected outcome onto a queue.
// A monitor pops an entry whenever valid or frame_err fires and compares it.
// Bits are timed in ticks, so pausing the tick stretches the frame in step.
module tb_uart_rx;

  localparam int OVERSAMPLE = 16;
  localparam int LATENCY    = 613;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  typedef struct {
    logic       is_err;
    logic [7:0] value;
    int         start_cycle;
    int         exp_latency;
  } sb_entry_t;

  sb_entry_t sbq[$];
  sb_entry_t mon_entry;

  int         test_count = 0;
  int         fail_count = 0;
  int         cycle_cnt  = 0;
  int         busy_count = 0;
  logic       tick_en    = 1'b1;
  logic [1:0] div_cnt    = '0;
  logic [7:0] last_good  = 8'h00;
  logic       prev_strobe = 1'b0;

  uart_rx #(.OVERSAMPLE(OVERSAMPLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // 10 ns system clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running cycle count used for latency measurements.
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Tick every fourth clock; disabling freezes the divider so the pause is exact.
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        tick    = (div_cnt == 2'd3);
        div_cnt = div_cnt + 2'd1;
      end else begin
        tick = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Scoreboard monitor: each strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (valid || frame_err)) begin
      if (valid && frame_err) checkOutput("strobe_exclusive", 32'd1, 32'd0);
      if (prev_strobe) checkOutput("strobe_width", 32'd1, 32'd0);
      if (sbq.size() == 0) begin
        checkOutput("unexpected_strobe", {30'd0, valid, frame_err}, 32'd0);
      end else begin
        mon_entry = sbq.pop_front();
        checkOutput("strobe_kind", {31'd0, frame_err}, {31'd0, mon_entry.is_err});
        if (!mon_entry.is_err) begin
          checkOutput("data", {24'd0, data}, {24'd0, mon_entry.value});
          last_good = mon_entry.value;
        end else begin
          checkOutput("data_hold", {24'd0, data}, {24'd0, last_good});
        end
        if (mon_entry.exp_latency != 0)
          checkOutput("latency", cycle_cnt - mon_entry.start_cycle, mon_entry.exp_latency);
      end
    end
    prev_strobe = rst_n && (valid || frame_err);
    if (busy) busy_count++;
  end

  task automatic waitTicks(input int n);
    int seen = 0;
    while (seen < n) begin
      @(negedge clk);
      if (tick) seen++;
    end
  endtask

  task automatic driveBit(input logic b);
    rx = b;
    waitTicks(OVERSAMPLE);
  endtask

  task automatic applyStimulus(input logic [7:0] value, input logic stop_bit, input int exp_latency);
    sb_entry_t e;
    e.is_err      = !stop_bit;
    e.value       = value;
    e.start_cycle = cycle_cnt;
    e.exp_latency = exp_latency;
    sbq.push_back(e);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(value[i]);
    driveBit(stop_bit);
  endtask

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_data", {24'd0, data}, 32'h00);
    checkOutput("reset_valid", {31'd0, valid}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    waitTicks(20);

    $display("[TB] good byte 0xA5");
    applyStimulus(8'hA5, 1'b1, LATENCY);
    waitTicks(20);
    checkOutput("busy_after_good", {31'd0, busy}, 32'd0);

    $display("[TB] back-to-back 0x00 0xFF 0x3C");
    applyStimulus(8'h00, 1'b1, LATENCY);
    applyStimulus(8'hFF, 1'b1, LATENCY);
    applyStimulus(8'h3C, 1'b1, LATENCY);
    waitTicks(20);

    $display("[TB] false start");
    busy_count = 0;
    rx = 1'b0;
    waitTicks(3);
    rx = 1'b1;
    waitTicks(20);
    checkOutput("false_start_busy_short", {31'd0, (busy_count > 0) && (busy_count <= 8 * 4)}, 32'd1);
    checkOutput("false_start_idle", {31'd0, busy}, 32'd0);

    $display("[TB] framing error then break");
    applyStimulus(8'h55, 1'b0, 0);
    for (int i = 0; i < 40; i++) driveBit(1'b0);
    checkOutput("break_busy", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    waitTicks(20);
    checkOutput("break_released_idle", {31'd0, busy}, 32'd0);
    applyStimulus(8'h81, 1'b1, LATENCY);
    waitTicks(20);

    $display("[TB] reset mid-frame");
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(1'b1);
    rx = 1'b0;
    waitTicks(8);
    rst_n = 1'b0;
    last_good = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("midreset_data", {24'd0, data}, 32'h00);
    checkOutput("midreset_valid", {31'd0, valid}, 32'd0);
    checkOutput("midreset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    waitTicks(40);
    applyStimulus(8'h5A, 1'b1, LATENCY);
    waitTicks(20);

    $display("[TB] tick gating");
    fork
      applyStimulus(8'h96, 1'b1, LATENCY + 100);
      begin
        repeat (200) @(negedge clk);
        tick_en = 1'b0;
        repeat (100) @(negedge clk);
        checkOutput("pause_busy", {31'd0, busy}, 32'd1);
        tick_en = 1'b1;
      end
    join
    waitTicks(20);

    for (int i = 0; i < 2000 && sbq.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drained", sbq.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
